// File: rtl/text_console.sv
// Byte-stream text console that writes printable characters into a character buffer.
// Optional screen clear on form feed is built when TEXT_CONSOLE_CLEAR_EN is defined.
module text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [11:0] char_write_read_addr,
  output logic [7:0]  char_write_data,
  output logic        char_write_enable,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [7:0]  SPACE    = 8'h20;

  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        accept;
  logic [11:0] cur_addr;
  logic [4:0]  row_inc;
  logic        is_print;
  logic        is_lf;
  logic        is_cr;
  logic        is_bs;

`ifdef TEXT_CONSOLE_CLEAR_EN
  localparam logic [11:0] CELL_LAST = 12'(COLS * ROWS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e state_q, state_d;
  logic   is_ff;

  assign is_ff    = in_data == 8'h0C;
  assign in_ready = state_q == IDLE;
  assign busy     = state_q == CLEAR;
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  assign accept   = in_valid & in_ready;
  assign cur_addr = 12'(row_q) * COLS_W + 12'(col_q);
  assign row_inc  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
  assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign is_lf    = in_data == 8'h0A;
  assign is_cr    = in_data == 8'h0D;
  assign is_bs    = in_data == 8'h08;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
`ifdef TEXT_CONSOLE_CLEAR_EN
    state_d = state_q;
    // Clear sweeps the whole buffer, then homes the cursor.
    if (state_q == CLEAR) begin
      if (addr_q == CELL_LAST) begin
        state_d = IDLE;
        col_d   = 7'd0;
        row_d   = 5'd0;
      end else begin
        we_d   = 1'b1;
        addr_d = addr_q + 12'd1;
      end
    end else
`endif
    if (accept) begin
      unique case (1'b1)
        is_print: begin
          we_d   = 1'b1;
          addr_d = cur_addr;
          data_d = in_data;
          if (col_q == COL_LAST) begin
            col_d = 7'd0;
            row_d = row_inc;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        is_lf: begin
          col_d = 7'd0;
          row_d = row_inc;
        end
        is_cr: begin
          col_d = 7'd0;
        end
        (is_bs && col_q != 7'd0): begin
          col_d  = col_q - 7'd1;
          we_d   = 1'b1;
          addr_d = cur_addr - 12'd1;
          data_d = SPACE;
        end
`ifdef TEXT_CONSOLE_CLEAR_EN
        is_ff: begin
          state_d = CLEAR;
          we_d    = 1'b1;
          addr_d  = 12'd0;
          data_d  = SPACE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= 7'd0;
      row_q  <= 5'd0;
      we_q   <= 1'b0;
      addr_q <= 12'd0;
      data_q <= 8'd0;
`ifdef TEXT_CONSOLE_CLEAR_EN
      state_q <= IDLE;
`endif
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef TEXT_CONSOLE_CLEAR_EN
      state_q <= state_d;
`endif
    end
  end

  assign char_write_read_addr = addr_q;
  assign char_write_data      = data_q;
  assign char_write_enable    = we_q;
  assign cursor_col           = col_q;
  assign cursor_row           = row_q;

endmodule
